// File: rtl/ternary_host_driver_pkg.sv
// ternary_host_driver_pkg: shared FSM states, command codes and bus geometry for the ternary host driver
package ternary_host_driver_pkg;
   localparam int BUS_W = 16;
   localparam int CMD_HI = 13;
   localparam int CMD_LO = 12;
   localparam logic [1:0] CMD_LOAD = 2'b10;
   localparam logic [1:0] CMD_MULT = 2'b11;
   typedef enum logic [2:0] {IDLE, FILL, DUT_RST, CMD, LOAD, MULT} state_t;
   function automatic logic [BUS_W-1:0] cmd_word(input logic [1:0] code);
      logic [BUS_W-1:0] w;
      w = '0;
      w[CMD_HI:CMD_LO] = code;
      return w;
   endfunction
endpackage

// File: rtl/ternary_wt_buffer.sv
// ternary_wt_buffer: weight word store, one write port and one combinational read port
module ternary_wt_buffer
   import ternary_host_driver_pkg::*;
#(
   parameter int N_WORDS = 16,
   parameter int AW = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [BUS_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [BUS_W-1:0] rd_data
);
   logic [BUS_W-1:0] mem [N_WORDS];
   // contents survive reset; only a new fill rewrites them
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ternary_host_driver.sv
// ternary_host_driver: buffers weights, resets and commands the target, streams load words and vector sweeps
module ternary_host_driver
   import ternary_host_driver_pkg::*;
#(
   parameter int N_WORDS = 16,
   parameter int N_ROWS = 8,
   parameter int RES_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wt_valid,
   input  logic [BUS_W-1:0] wt_data,
   output logic             wt_ready,
   input  logic             vec_valid,
   input  logic [BUS_W-1:0] vec_data,
   output logic             vec_ready,
   input  logic             start,
   input  logic             with_load,
   output logic [BUS_W-1:0] dut_bus,
   output logic             dut_rst_n,
   input  logic [7:0]       dut_out,
   output logic             res_valid,
   output logic [2:0]       res_row,
   output logic [7:0]       res_data,
   output logic             busy,
   output logic             underrun
);
   localparam int AW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
   state_t state;
   logic [AW-1:0] idx, cnt;
   logic [2:0] row;
   logic [BUS_W-1:0] bus_q, rd_data;
   logic load, ok;
   logic row0, row_valid;
   logic pv [RES_LAT];
   logic [2:0] pr [RES_LAT];

   assign row0 = (state == MULT) && (row == '0);
   assign row_valid = (state == MULT) && (row0 ? vec_valid : ok);
   assign vec_ready = row0 && vec_valid;
   assign dut_bus = (state == LOAD) ? rd_data : row0 ? (vec_valid ? vec_data : '0) : bus_q;
   assign res_valid = pv[RES_LAT-1];
   assign res_row = pr[RES_LAT-1];
   assign res_data = res_valid ? dut_out : '0;

   ternary_wt_buffer #(.N_WORDS(N_WORDS), .AW(AW)) u_buf (
      .clk(clk), .we(wt_ready && wt_valid), .wr_addr(idx), .wr_data(wt_data),
      .rd_addr(cnt), .rd_data(rd_data)
   );

   // sequencer: state plus registered control outputs set on each transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         wt_ready <= 1'b0;
         dut_rst_n <= 1'b0;
         bus_q <= '0;
         idx <= '0;
         cnt <= '0;
         row <= '0;
         load <= 1'b0;
         ok <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               load <= with_load;
               idx <= '0;
               cnt <= '0;
               wt_ready <= with_load;
               state <= with_load ? FILL : DUT_RST;
            end
            FILL: if (wt_valid) begin
               idx <= idx + 1'b1;
               if (idx == AW'(N_WORDS - 1)) begin
                  wt_ready <= 1'b0;
                  state <= DUT_RST;
               end
            end
            DUT_RST: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(1)) begin
                  dut_rst_n <= 1'b1;
                  bus_q <= cmd_word(load ? CMD_LOAD : CMD_MULT);
                  state <= CMD;
               end
            end
            CMD: begin
               bus_q <= '0;
               cnt <= '0;
               row <= '0;
               state <= load ? LOAD : MULT;
            end
            LOAD: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(N_WORDS - 1)) state <= MULT;
            end
            MULT: begin
               row <= (row == 3'(N_ROWS - 1)) ? '0 : row + 1'b1;
               if (row == '0) begin
                  ok <= vec_valid;
                  bus_q <= vec_valid ? vec_data : '0;
                  underrun <= !vec_valid;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // result pipe: each row's {valid,row} emerges RES_LAT cycles after it was driven
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RES_LAT; i++) begin
            pv[i] <= 1'b0;
            pr[i] <= '0;
         end
      end else begin
         pv[0] <= row_valid;
         pr[0] <= row;
         for (int i = 1; i < RES_LAT; i++) begin
            pv[i] <= pv[i-1];
            pr[i] <= pr[i-1];
         end
      end
   end
endmodule

// File: tb/tb_ternary_host_driver.sv
// tb_ternary_host_driver: directed checks of load, multiply, underrun and reset behaviour
module tb_ternary_host_driver;
   localparam int LAT = 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wt_valid = 1'b0, vec_valid = 1'b0, start = 1'b0, with_load = 1'b0;
   logic [15:0] wt_data = '0, vec_data = '0, dut_bus;
   logic wt_ready, vec_ready, dut_rst_n, res_valid, busy, underrun;
   logic [2:0] res_row;
   logic [7:0] res_data;
   logic [7:0] dut_out = '0;
   logic [2:0] m_row = '0;
   int n_chk = 0, n_fail = 0;

   ternary_host_driver #(.N_WORDS(16), .N_ROWS(8), .RES_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
      .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
      .start(start), .with_load(with_load), .dut_bus(dut_bus), .dut_rst_n(dut_rst_n),
      .dut_out(dut_out), .res_valid(res_valid), .res_row(res_row), .res_data(res_data),
      .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // target model: row counter restarts after a MULT command, output = row + 0x40 one cycle later
   always @(posedge clk) begin
      m_row <= (dut_bus == 16'h3000) ? 3'd0 : m_row + 3'd1;
      dut_out <= 8'h40 + {5'd0, m_row};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic go(input logic ld);
      start = 1'b1;
      with_load = ld;
      tick();
      start = 1'b0;
   endtask

   task automatic fill(input logic [15:0] base, input int n, input bit tog);
      int got = 0;
      int c = 0;
      logic acc;
      while (got < n && c < 200) begin
         wt_valid = !tog || (c % 2 == 0);
         wt_data = base + 16'(got);
         #1;
         acc = wt_valid && wt_ready;
         tick();
         if (acc) got++;
         c++;
      end
      wt_valid = 1'b0;
      if (got < n) chk("fill_timeout", got, n);
   endtask

   task automatic seq(input logic ld, input logic [15:0] base, input int nl);
      for (int i = 0; i < 2; i++) begin
         chk("dutrst_rstn", dut_rst_n, 0);
         chk("dutrst_bus", dut_bus, 0);
         tick();
      end
      chk("cmd_bus", dut_bus, ld ? 32'h2000 : 32'h3000);
      chk("cmd_rstn", dut_rst_n, 1);
      tick();
      if (ld) begin
         for (int k = 0; k < nl; k++) begin
            chk("load_bus", dut_bus, base + 16'(k));
            tick();
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_dut_rstn", dut_rst_n, 0);
      chk("rst_wt_ready", wt_ready, 0);
      chk("rst_vec_ready", vec_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_bus", dut_bus, 0);
      chk("rst_res_row", res_row, 0);
      chk("rst_res_data", res_data, 0);
      rst_n = 1'b1;
      tick();
      wt_valid = 1'b1;
      #1;
      chk("idle_no_wt_ready", wt_ready, 0);
      wt_valid = 1'b0;

      // load then multiply with contiguous weight words
      go(1'b1);
      chk("fill_busy", busy, 1);
      chk("fill_wt_ready", wt_ready, 1);
      fill(16'h0001, 16, 1'b0);
      chk("post_fill_wt_ready", wt_ready, 0);
      seq(1'b1, 16'h0001, 16);
      vec_valid = 1'b1;
      vec_data = 16'h00FF;
      #1;
      chk("mult_vec_ready", vec_ready, 1);
      chk("mult_bus", dut_bus, 16'h00FF);

      // multiply only: two valid sweeps around one underrun sweep
      do_reset();
      go(1'b0);
      seq(1'b0, 16'h0000, 0);
      for (int t = 0; t <= 24; t++) begin
         vec_valid = (t != 8);
         #1;
         chk("sw_bus", dut_bus, (t / 8 == 1) ? 32'h0 : 32'h00FF);
         chk("sw_vec_ready", vec_ready, (t % 8 == 0) && (t != 8));
         chk("sw_underrun", underrun, t == 9);
         chk("sw_res_valid", res_valid, (t >= LAT) && ((t - LAT) / 8 != 1));
         if (t >= LAT && (t - LAT) / 8 != 1) begin
            chk("sw_res_row", res_row, (t - LAT) % 8);
            chk("sw_res_data", res_data, 8'h40 + (t - LAT) % 8);
         end
         tick();
      end

      // gappy weight stream must store the same words, and start in MULT is ignored
      do_reset();
      go(1'b1);
      fill(16'h0001, 16, 1'b1);
      seq(1'b1, 16'h0001, 16);
      vec_valid = 1'b1;
      tick();
      tick();
      start = 1'b1;
      with_load = 1'b1;
      wt_valid = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk("mult_start_wt_ready", wt_ready, 0);
      chk("mult_start_busy", busy, 1);
      chk("mult_start_rstn", dut_rst_n, 1);
      chk("mult_start_bus", dut_bus, 16'h00FF);
      wt_valid = 1'b0;

      // reset in the middle of LOAD
      do_reset();
      go(1'b1);
      fill(16'h0100, 16, 1'b0);
      seq(1'b1, 16'h0100, 7);
      chk("load7_bus", dut_bus, 16'h0107);
      rst_n = 1'b0;
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_rstn", dut_rst_n, 0);
      chk("abort_bus", dut_bus, 0);
      rst_n = 1'b1;
      tick();

      // partial fill discarded by reset, fresh fill starts at index 0
      go(1'b1);
      fill(16'hAAAA, 5, 1'b0);
      do_reset();
      go(1'b1);
      fill(16'h0201, 16, 1'b0);
      seq(1'b1, 16'h0201, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ternary_host_driver.md
TERNARY_HOST_DRIVER -- requirements
Module: ternary_host_driver

Interface
REQ-001 SHALL have parameter N_WORDS, default 16, meaning the number of 16-bit weight words per full matrix load.
REQ-002 SHALL have parameter N_ROWS, default 8, meaning the number of output rows per vector sweep.
REQ-003 SHALL have parameter RES_LAT, default 1, meaning the cycles from driving a MULT word to its valid dut_out row (range 1..3).
REQ-004 SHALL have port: clk  in  1  the single clock.
REQ-005 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports: wt_valid in 1, wt_data in 16, wt_ready out 1; this is the weight-word input stream.
REQ-007 SHALL have ports: vec_valid in 1, vec_data in 16, vec_ready out 1; this is the activation-vector input stream.
REQ-008 SHALL have ports: start in 1 (one-cycle pulse) and with_load in 1 (sampled with start; 1 = load then multiply, 0 = multiply only).
REQ-009 SHALL have ports: dut_bus out 16 (the target's {ui_in,uio_in}, command field at [13:12]), dut_rst_n out 1, and dut_out in 8.
REQ-010 SHALL have ports: res_valid out 1, res_row out 3, res_data out 8, busy out 1, underrun out 1.

Function
REQ-011 SHALL implement the FSM states IDLE, FILL, DUT_RST, CMD, LOAD, MULT.
REQ-012 In IDLE, a start with with_load=1 SHALL go to FILL; a start with with_load=0 SHALL go to DUT_RST; start SHALL be ignored while busy=1.
REQ-013 In FILL, wt_ready=1 and the block SHALL write each accepted word into a N_WORDS x 16 buffer at an incrementing index; when index N_WORDS-1 is written, it SHALL go to DUT_RST the next cycle.
REQ-014 In DUT_RST, dut_rst_n=0 and dut_bus=0 SHALL hold for exactly 2 cycles, then the FSM SHALL go to CMD.
REQ-015 In CMD, for exactly 1 cycle, dut_bus[13:12] SHALL be 2'b10 if loading, else 2'b11, with all other bits 0; the next state SHALL be LOAD or MULT accordingly.
REQ-016 In LOAD, dut_bus SHALL equal buffer[k] on cycle k = 0..N_WORDS-1, with no stalls; after word N_WORDS-1 the FSM SHALL go to MULT.
REQ-017 In MULT, a 3-bit row counter SHALL start at 0 on the first MULT cycle and increment every cycle, wrapping N_ROWS-1 -> 0.
REQ-018 At row 0, if vec_valid=1, the block SHALL assert vec_ready for that cycle, latch vec_data, and drive it on dut_bus for rows 0..N_ROWS-1.
REQ-019 If vec_valid=0 at row 0, the block SHALL drive dut_bus=0 for that sweep, pulse underrun for 1 cycle, and suppress res_valid for that sweep.
REQ-020 For a valid sweep, res_valid SHALL be 1 exactly RES_LAT cycles after each row cycle, with res_row = that row and res_data = dut_out sampled that cycle.
REQ-021 MULT SHALL persist until rst_n=0; results of the last sweep SHALL still emit RES_LAT cycles later.
REQ-022 busy SHALL be 0 only in IDLE.
REQ-023 wt_ready SHALL be 1 only in FILL, and vec_ready SHALL be 1 only per REQ-018.
REQ-024 Weight words presented outside FILL SHALL NOT be consumed.
REQ-025 A buffer left from a previous FILL SHALL be overwritten only by a new FILL.

Reset
REQ-026 rst_n=0 SHALL return the FSM to IDLE on the next edge from any state, including mid-FILL and mid-LOAD.
REQ-027 During and after reset, dut_rst_n SHALL be 0, with busy, wt_ready, vec_ready, res_valid and underrun all 0.
REQ-028 Reset SHALL clear dut_bus, res_row, res_data, the row counter and the fill index to 0.
REQ-029 Buffer contents SHALL NOT require reset.
REQ-030 A partially filled buffer SHALL be discarded by reset, so the next FILL starts at index 0.

Structure
REQ-031 A shared package SHALL hold the state enum, the CMD_LOAD=2'b10 and CMD_MULT=2'b11 codes, the command bit positions 13:12, and the bus width 16.
REQ-032 The weight buffer SHALL be one sub-module, ternary_wt_buffer (single write port, single read port, combinational read).
REQ-033 The result-latency pipe SHALL be inline RES_LAT-stage shift registers carrying {valid,row}.

Verification
REQ-034 Reset then start with_load=1 and 16 words 0x0001..0x0010 -> dut_rst_n=0 for 2 cycles, one cycle dut_bus=0x2000, then 0x0001..0x0010 on consecutive cycles, then MULT.
REQ-035 with_load=0 and vec 0x00FF always valid, with dut_out model = row+0x40 -> dut_bus=0x3000 for 1 cycle, then 0x00FF for 8 cycles, and res_row 0..7 with res_data 0x40..0x47 at RES_LAT=1.
REQ-036 vec_valid=0 at the second sweep's row 0 -> underrun pulse once, dut_bus=0 for 8 cycles, no res_valid for that sweep, and the third sweep normal.
REQ-037 wt_valid toggling 1,0,1,0 during FILL -> exactly 16 words stored in order and LOAD output unchanged versus REQ-034.
REQ-038 rst_n=0 at LOAD word 7 -> IDLE next cycle with busy=0, and a fresh start reloads from index 0.
REQ-039 A start pulse while in MULT -> no state change and no wt_ready.
